nf10_axis_rr_input_arbiter: RTL and testbench
=============================================

Name: nf10_axis_rr_input_arbiter

Overview:
- Packet-granular round-robin arbiter that merges C_NUM_PORTS AXI4-Stream slave inputs onto one 256-bit master output.
- The inputs are the 10G interface RX streams plus the DMA stream. The output feeds the output-port-lookup stage.
- Whole packets are never interleaved. tuser (src/dst port metadata) passes through unchanged on every beat.
- Fairness is guaranteed: every requesting port is served within C_NUM_PORTS packet grants.

Parameters:
- C_NUM_PORTS, 4: number of slave stream inputs (2..8).
- C_AXIS_DATA_WIDTH, 256: tdata width; tstrb width is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128: tuser width.

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  C_NUM_PORTS*C_AXIS_DATA_WIDTH  flattened; port i occupies slice i.
- s_axis_tstrb  in  C_NUM_PORTS*C_AXIS_DATA_WIDTH/8  flattened byte strobes.
- s_axis_tuser  in  C_NUM_PORTS*C_AXIS_TUSER_WIDTH  flattened metadata.
- s_axis_tvalid  in  C_NUM_PORTS  per-port valid.
- s_axis_tlast  in  C_NUM_PORTS  per-port last.
- s_axis_tready  out  C_NUM_PORTS  per-port ready.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  merged data.
- m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  merged strobes.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  merged metadata.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  merged last.
- cur_grant  out  clog2(C_NUM_PORTS)  currently granted port, for debug.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, last_grant=C_NUM_PORTS-1, so port 0 has first priority.
  - m_axis_tvalid=0, all s_axis_tready=0, cur_grant=0.
- State IDLE:
  - If any s_axis_tvalid[i]=1, pick the first requester scanning last_grant+1, last_grant+2, ... with wrap modulo C_NUM_PORTS.
  - Register the pick into grant and last_grant; next state PKT.
  - If there are no requesters, stay in IDLE.
  - All tready are 0 in IDLE, so no beat is ever consumed in IDLE.
- State PKT (g = grant):
  - m_axis_tdata/tstrb/tuser/tlast/tvalid are combinational muxes of slave port g.
  - s_axis_tready[g] = m_axis_tready; every other tready is 0.
  - A beat transfers when s_axis_tvalid[g] && m_axis_tready.
  - A transfer with tlast=1 returns the state to IDLE.
  - Otherwise stay in PKT, including when port g drops tvalid mid-packet; the output tvalid drops with it and other ports stay blocked.
- Latency and throughput:
  - One bubble cycle per packet: the IDLE arbitration cycle. First beat of a packet appears the cycle after the request is seen.
  - Data path is 0-cycle, with no buffering.
  - Back-to-back packets from one sole requester: grant repeats after the bubble.
- Requests that change during the IDLE cycle affect only that cycle's pick; there is no request latching.
- Single-beat packets (tvalid & tlast on the first beat): PKT lasts exactly one transfer cycle.
- m_axis_tready low during PKT: hold the grant indefinitely, with no timeout.
- Reset asserted mid-packet: immediate return to the reset state. The partial packet is truncated downstream; upstream recovery is not this block's concern.
- Width rules:
  - grant and last_grant are clog2(C_NUM_PORTS) bits.
  - Wrap arithmetic is modulo C_NUM_PORTS, so non-power-of-2 counts are legal.

Optional Feature:
- Macro: NF10_ARB_PKT_COUNT_EN.
- When defined:
  - Adds output pkt_count [C_NUM_PORTS*32-1:0], one 32-bit counter per port.
  - A port's counter increments on each accepted tlast beat from that port.
  - Counters wrap at 2^32-1 → 0 and reset to 0.
- When undefined: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package nf10_arb_pkg:
  - State enum {IDLE, PKT}.
  - Function clog2.
  - Constant C_MAX_PORTS=8.
- One sub-module: nf10_rr_pick, purely combinational.
  - Inputs: req vector and last_grant.
  - Outputs: any_req and the next grant index.
  - Reusable by the output-queue scheduler.

Test Plan:
- Single port: port 1 sends a 3-beat packet, m_axis_tready=1 → grant=1 after 1 bubble; m_axis shows 3 beats with tlast on beat 3; then IDLE.
- Fairness: all 4 ports continuously send 2-beat packets → output packet order 0,1,2,3,0,1,...; each packet takes 3 cycles (1 idle + 2 beats).
- Backpressure: m_axis_tready toggles 1,0,1,0 during a 4-beat packet from port 2 → exactly 4 transfers; no other port's tready ever goes high; port 2's tdata appears unchanged.
- Mid-packet gap: port 0 deasserts tvalid for 5 cycles mid-packet while port 3 requests → port 3 is not granted until port 0's tlast is accepted.
- Reset mid-packet: axi_resetn low for 1 cycle during beat 2 → m_axis_tvalid=0 and all tready=0 in the same cycle; after release, port 0 has priority.
- NF10_ARB_PKT_COUNT_EN: 5 packets from port 1 and 2 from port 3 → pkt_count slice 1 reads 5, slice 3 reads 2, others 0.

Source files
------------

// File: rtl/nf10_arb_pkg.sv
// ============================================================================
// Module   : nf10_arb_pkg (package)
// Purpose  : Shared types, constants and helpers for the NF10 stream
//            arbiters (input arbiter and output-queue scheduler).
// Contents : arb_state_t  - packet arbiter state {IDLE, PKT}
//            C_MAX_PORTS  - largest supported port count
//            clog2()      - ceiling log2, usable in port width expressions
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nf10_arb_pkg;

    localparam int C_MAX_PORTS = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PKT  = 1'b1
    } arb_state_t;

    // Ceiling log2 of value; clog2(2)=1, clog2(4)=2, clog2(5)=3.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nf10_rr_pick.sv
// ============================================================================
// Module   : nf10_rr_pick
// Purpose  : Purely combinational round-robin picker. Given a request vector
//            and the index granted last, returns the first requester found
//            scanning last+1, last+2, ... modulo NUM_PORTS. Works for any
//            port count, power of two or not.
// Ports    : i_req        [NUM_PORTS-1:0] request vector
//            i_last_grant [GRANT_W-1:0]   most recently granted index
//            o_any_req                    at least one request present
//            o_grant      [GRANT_W-1:0]   next grant (valid when o_any_req)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nf10_rr_pick
    import nf10_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int GRANT_W   = clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [GRANT_W-1:0]   i_last_grant,
    output logic                 o_any_req,
    output logic [GRANT_W-1:0]   o_grant
);

    int w_idx;

    always_comb begin
        w_idx     = 0;
        o_any_req = |i_req;
        o_grant   = i_last_grant;
        // Walk the ring from the farthest offset to the nearest one so the
        // final hit is the closest requester after i_last_grant. Offset
        // NUM_PORTS lands on i_last_grant itself, so a sole requester that
        // was just served is picked again.
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_idx = (int'(i_last_grant) + k) % NUM_PORTS;
            if (i_req[GRANT_W'(w_idx)]) begin
                o_grant = GRANT_W'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/nf10_axis_rr_input_arbiter.sv
// ============================================================================
// Module   : nf10_axis_rr_input_arbiter
// Purpose  : Packet-granular round-robin merge of C_NUM_PORTS AXI4-Stream
//            slave inputs (10G RX + DMA) onto one master stream feeding the
//            output-port-lookup stage. Packets are never interleaved; tuser
//            passes through unchanged. One arbitration bubble per packet,
//            zero-cycle data path with no buffering.
// Ports    : axi_aclk, axi_resetn (async assert, active low)
//            s_axis_tdata/tstrb/tuser  flattened per-port slices
//            s_axis_tvalid/tlast       per-port, s_axis_tready per-port out
//            m_axis_tdata/tstrb/tuser/tvalid/tlast out, m_axis_tready in
//            cur_grant                 currently/last granted port (debug)
//            pkt_count                 per-port 32-bit packet counters,
//                                      present only with the macro below
// Options  : NF10_ARB_PKT_COUNT_EN - adds pkt_count[C_NUM_PORTS*32-1:0],
//            incremented on every accepted tlast beat of the owning port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nf10_axis_rr_input_arbiter
    import nf10_arb_pkg::*;
#(
    parameter int C_NUM_PORTS        = 4,
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                        axi_aclk,
    input  logic                                        axi_resetn,

    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                      s_axis_tvalid,
    input  logic [C_NUM_PORTS-1:0]                      s_axis_tlast,
    output logic [C_NUM_PORTS-1:0]                      s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic                                        m_axis_tlast,

    output logic [clog2(C_NUM_PORTS)-1:0]               cur_grant
`ifdef NF10_ARB_PKT_COUNT_EN
    ,
    output logic [C_NUM_PORTS*32-1:0]                   pkt_count
`endif
);

    localparam int C_GRANT_W = clog2(C_NUM_PORTS);
    localparam int C_STRB_W  = C_AXIS_DATA_WIDTH / 8;
    localparam logic [C_GRANT_W-1:0] C_LAST_PORT = C_GRANT_W'(C_NUM_PORTS - 1);

    // ------------------------------------------------------------------
    // Unpack the flattened slave buses into per-port arrays
    // ------------------------------------------------------------------
    logic [C_AXIS_DATA_WIDTH-1:0]  w_tdata_arr [C_NUM_PORTS];
    logic [C_STRB_W-1:0]           w_tstrb_arr [C_NUM_PORTS];
    logic [C_AXIS_TUSER_WIDTH-1:0] w_tuser_arr [C_NUM_PORTS];

    genvar gu;
    generate
        for (gu = 0; gu < C_NUM_PORTS; gu++) begin : g_unpack
            assign w_tdata_arr[gu] = s_axis_tdata[gu*C_AXIS_DATA_WIDTH  +: C_AXIS_DATA_WIDTH];
            assign w_tstrb_arr[gu] = s_axis_tstrb[gu*C_STRB_W           +: C_STRB_W];
            assign w_tuser_arr[gu] = s_axis_tuser[gu*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    arb_state_t             r_state;
    logic [C_GRANT_W-1:0]   r_grant;
    logic [C_GRANT_W-1:0]   r_last_grant;

    logic                   w_any_req;
    logic [C_GRANT_W-1:0]   w_pick;
    logic                   w_in_pkt;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic                   w_xfer;

    nf10_rr_pick #(
        .NUM_PORTS    (C_NUM_PORTS),
        .GRANT_W      (C_GRANT_W)
    ) u_rr_pick (
        .i_req        (s_axis_tvalid),
        .i_last_grant (r_last_grant),
        .o_any_req    (w_any_req),
        .o_grant      (w_pick)
    );

    assign w_in_pkt    = (r_state == PKT);
    assign w_sel_valid = w_in_pkt & s_axis_tvalid[r_grant];
    assign w_sel_last  = w_in_pkt & s_axis_tlast[r_grant];
    assign w_xfer      = w_sel_valid & m_axis_tready;

    // IDLE is a pure arbitration cycle: nothing is accepted, the pick is
    // taken from whatever requests are present in that single cycle.
    // PKT holds the grant until the granted port's tlast beat is accepted,
    // regardless of tvalid gaps or downstream backpressure.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= C_LAST_PORT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_state      <= PKT;
                    end
                end
                PKT: begin
                    if (w_xfer && w_sel_last) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Zero-latency data path: the granted slave drives the master port.
    // Data/strb/user are left muxed in IDLE; tvalid/tlast qualify them.
    // ------------------------------------------------------------------
    assign m_axis_tdata  = w_tdata_arr[r_grant];
    assign m_axis_tstrb  = w_tstrb_arr[r_grant];
    assign m_axis_tuser  = w_tuser_arr[r_grant];
    assign m_axis_tvalid = w_sel_valid;
    assign m_axis_tlast  = w_sel_last;

    assign s_axis_tready = (w_in_pkt && m_axis_tready)
                         ? (C_NUM_PORTS'(1) << r_grant)
                         : '0;

    assign cur_grant = r_grant;

`ifdef NF10_ARB_PKT_COUNT_EN
    // ------------------------------------------------------------------
    // Per-port accepted-packet counters, free-running with natural wrap
    // ------------------------------------------------------------------
    genvar gc;
    generate
        for (gc = 0; gc < C_NUM_PORTS; gc++) begin : g_pkt_count
            logic [31:0] r_cnt;

            always_ff @(posedge axi_aclk or negedge axi_resetn) begin
                if (!axi_resetn) begin
                    r_cnt <= '0;
                end else if (w_xfer && w_sel_last && (r_grant == C_GRANT_W'(gc))) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end

            assign pkt_count[gc*32 +: 32] = r_cnt;
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_nf10_axis_rr_input_arbiter.sv
// ============================================================================
// Module   : tb_nf10_axis_rr_input_arbiter
// Purpose  : Randomized self-checking bench for nf10_axis_rr_input_arbiter.
//            A behavioural round-robin model predicts every accepted beat
//            into a queue; an independent monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nf10_axis_rr_input_arbiter;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int UW = 128;

    logic                axi_aclk = 1'b0;
    logic                axi_resetn;
    logic [N*DW-1:0]     s_axis_tdata;
    logic [N*SW-1:0]     s_axis_tstrb;
    logic [N*UW-1:0]     s_axis_tuser;
    logic [N-1:0]        s_axis_tvalid;
    logic [N-1:0]        s_axis_tlast;
    logic [N-1:0]        s_axis_tready;
    logic [DW-1:0]       m_axis_tdata;
    logic [SW-1:0]       m_axis_tstrb;
    logic [UW-1:0]       m_axis_tuser;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                m_axis_tlast;
    logic [1:0]          cur_grant;
`ifdef NF10_ARB_PKT_COUNT_EN
    logic [N*32-1:0]     pkt_count;
`endif

    always #5 axi_aclk = ~axi_aclk;

    nf10_axis_rr_input_arbiter #(
        .C_NUM_PORTS        (N),
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_resetn    (axi_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .cur_grant     (cur_grant)
`ifdef NF10_ARB_PKT_COUNT_EN
        ,
        .pkt_count     (pkt_count)
`endif
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: packets are whole units; when no packet is open,
    // the first valid port after the previously served one opens a packet
    // (that cycle carries no data); while open, every cycle where that
    // port is valid and downstream is ready moves one beat, and the beat
    // with tlast closes the packet.
    // ------------------------------------------------------------------
    bit          m_busy = 1'b0;
    int          m_last = N - 1;
    int          m_gnt  = 0;
    logic        exp_mvalid = 1'b0;
    logic [N-1:0] exp_sready = '0;
    logic [1:0]  exp_cur = '0;
    int          exp_cnt [N];

    always @(negedge axi_aclk) begin
        if (!axi_resetn) begin
            m_busy     = 1'b0;
            m_last     = N - 1;
            m_gnt      = 0;
            exp_mvalid = 1'b0;
            exp_sready = '0;
            exp_cur    = '0;
            exp_q.delete();
            for (int p = 0; p < N; p++) exp_cnt[p] = 0;
        end else begin
            exp_cur = 2'(m_gnt);
            if (!m_busy) begin
                exp_mvalid = 1'b0;
                exp_sready = '0;
                for (int k = 1; k <= N; k++) begin
                    int p;
                    p = (m_last + k) % N;
                    if (!m_busy && s_axis_tvalid[p]) begin
                        m_busy = 1'b1;
                        m_gnt  = p;
                        m_last = p;
                    end
                end
            end else begin
                exp_mvalid = s_axis_tvalid[m_gnt];
                exp_sready = '0;
                if (m_axis_tready) exp_sready[m_gnt] = 1'b1;
                if (exp_mvalid && m_axis_tready) begin
                    beat_t b;
                    b.d = s_axis_tdata[m_gnt*DW +: DW];
                    b.s = s_axis_tstrb[m_gnt*SW +: SW];
                    b.u = s_axis_tuser[m_gnt*UW +: UW];
                    b.l = s_axis_tlast[m_gnt];
                    exp_q.push_back(b);
                    if (b.l) begin
                        m_busy = 1'b0;
                        exp_cnt[m_gnt]++;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares control outputs each cycle and pops one expected
    // beat per observed output handshake.
    // ------------------------------------------------------------------
    always @(negedge axi_aclk) begin
        #1;
        chk("m_tvalid", 256'(m_axis_tvalid), 256'(exp_mvalid));
        chk("s_tready", 256'(s_axis_tready), 256'(exp_sready));
        chk("cur_grant", 256'(cur_grant), 256'(exp_cur));
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 256'(1), 256'(0));
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                chk("tdata", m_axis_tdata, b.d);
                chk("tstrb", 256'(m_axis_tstrb), 256'(b.s));
                chk("tuser", 256'(m_axis_tuser), 256'(b.u));
                chk("tlast", 256'(m_axis_tlast), 256'(b.l));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: per-port random packet sources plus random backpressure
    // ------------------------------------------------------------------
    bit          stop = 1'b1;
    int          ready_pct = 100;
    int          start_pct = 100;
    int          drop_pct  = 0;
    logic [N-1:0] act = '0;
    int          plen [N];
    int          bidx [N];

    task automatic new_beat(input int p);
        s_axis_tdata[p*DW +: DW] = rnd256();
        s_axis_tstrb[p*SW +: SW] = $urandom;
    endtask

    initial begin
        logic [N-1:0] xfer;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        forever begin
            @(negedge axi_aclk);
            xfer = s_axis_tvalid & s_axis_tready;
            @(posedge axi_aclk);
            #1;
            m_axis_tready = ($urandom_range(0, 99) < ready_pct);
            for (int p = 0; p < N; p++) begin
                if (!axi_resetn) begin
                    act[p]           = 1'b0;
                    s_axis_tvalid[p] = 1'b0;
                    s_axis_tlast[p]  = 1'b0;
                end else begin
                    if (xfer[p]) begin
                        bidx[p]++;
                        if (bidx[p] == plen[p]) act[p] = 1'b0;
                        else new_beat(p);
                    end
                    if (!act[p] && !stop && ($urandom_range(0, 99) < start_pct)) begin
                        act[p]  = 1'b1;
                        plen[p] = $urandom_range(1, 4);
                        bidx[p] = 0;
                        s_axis_tuser[p*UW +: UW] = {$urandom, $urandom, $urandom, $urandom};
                        new_beat(p);
                    end
                    s_axis_tvalid[p] = act[p] && ($urandom_range(0, 99) >= drop_pct);
                    s_axis_tlast[p]  = act[p] && (bidx[p] == plen[p] - 1);
                end
            end
        end
    end

    task automatic run_phase(input int rp, input int sp, input int dp, input int cycles);
        ready_pct = rp;
        start_pct = sp;
        drop_pct  = dp;
        stop      = 1'b0;
        repeat (cycles) @(posedge axi_aclk);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bit done;
        axi_resetn = 1'b0;
        repeat (3) @(posedge axi_aclk);
        #2;
        chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_s_tready", 256'(s_axis_tready), 256'(0));
        chk("rst_cur_grant", 256'(cur_grant), 256'(0));
        @(posedge axi_aclk);
        #3 axi_resetn = 1'b1;

        // Saturated fairness, then random traffic with backpressure/gaps.
        run_phase(100, 100, 0, 400);
        run_phase(50, 30, 20, 800);

        // Reset in the middle of a packet.
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge axi_aclk);
            if (m_busy) done = 1'b1;
        end
        chk("mid_pkt_found", 256'(done), 256'(1));
        @(posedge axi_aclk);
        #3 axi_resetn = 1'b0;
        #1;
        chk("midrst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("midrst_s_tready", 256'(s_axis_tready), 256'(0));
        chk("midrst_cur_grant", 256'(cur_grant), 256'(0));
        @(posedge axi_aclk);
        #3 axi_resetn = 1'b1;

        run_phase(70, 60, 40, 800);
        run_phase(100, 20, 0, 400);

        // Drain all open packets.
        stop = 1'b1;
        drop_pct  = 0;
        ready_pct = 100;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge axi_aclk);
            if (!m_busy && act == '0 && s_axis_tvalid == '0) done = 1'b1;
        end
        chk("drain", 256'(done), 256'(1));
        repeat (2) @(negedge axi_aclk);
        #2;
        chk("queue_empty", 256'(exp_q.size()), 256'(0));

`ifdef NF10_ARB_PKT_COUNT_EN
        for (int p = 0; p < N; p++) begin
            chk("pkt_count", 256'(pkt_count[p*32 +: 32]), 256'(32'(exp_cnt[p])));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
